instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction cache controller. Owns the PC, drives request/address into the cache controller, and captures hit responses into a small FIFO toward decode.
- Handles cache misses by holding address and request until a hit returns. The cache replays internally after the refill.
- Applies branch/jump redirects from execute without ever changing the cache address mid-access.

Parameters:
ADDR_SIZE, 32, PC / cache address width
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, fetch FIFO entries (power of 2, >=2)

Ports:
i_clk  input  1  system clock
i_areset_n  input  1  asynchronous active-low reset
o_req  output  1  request to cache controller
o_addr  output  ADDR_SIZE  fetch address to cache controller
i_instr_valid  input  1  cache hit response, single-cycle pulse
i_instruction  input  INST_SIZE  instruction from cache, valid with i_instr_valid
i_redirect  input  1  single-cycle redirect pulse from execute
i_redirect_pc  input  ADDR_SIZE  redirect target
o_valid  output  1  FIFO head valid to decode
o_instr  output  INST_SIZE  head instruction
o_pc  output  ADDR_SIZE  head PC
i_ready  input  1  decode accepts head

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_areset_n.
- Reset values:
  - pc=RESET_PC, state=RUN, FIFO empty, pending redirect cleared.
  - o_req=1, o_valid=0.
  - o_addr=RESET_PC, o_instr=0, o_pc=0.
- o_addr is always equal to pc. pc[1:0] is forced to 0, and redirect target bits [1:0] are ignored.
- Address stability rule: pc changes only in two cases.
  - The cycle after i_instr_valid.
  - While in STALL, where o_req=0 and no access is outstanding.
- States:
  - RUN:
    - o_req=1, held until i_instr_valid.
    - A miss yields no response. The cache refills and re-enters its tag check, and the held request then hits. Fetch waits indefinitely.
    - On i_instr_valid with no redirect (live or pending): push {pc, i_instruction}, then pc <= pc+4, wrapping modulo 2^ADDR_SIZE.
    - If FIFO count after this cycle == FIFO_DEPTH, go to STALL.
  - STALL:
    - o_req=0.
    - Return to RUN when the count after this cycle < FIFO_DEPTH. o_req is asserted in the same cycle as the pop.
- Redirect handling:
  - i_redirect flushes the FIFO in the same cycle. o_valid=0 the next cycle, and a simultaneous pop is discarded.
  - In STALL: pc <= i_redirect_pc next cycle, and go to RUN.
  - In RUN without i_instr_valid: latch target into pending_pc and set pending.
    - A later redirect overwrites pending_pc.
    - On the next i_instr_valid: drop the instruction (no push), pc <= pending_pc, clear pending.
  - In RUN with i_instr_valid in the same cycle: drop the instruction, pc <= i_redirect_pc.
- Throughput: hit-to-hit is 2 cycles per instruction, because the cache returns to idle after each hit.
- FIFO:
  - Push and pop are allowed in the same cycle.
  - A push never occurs when full; this is guaranteed by the STALL entry rule.
  - o_instr/o_pc are registered FIFO head outputs.
- Reset mid-access: the cache and fetch reset together. The cache flush keeps fetch waiting in RUN with o_req=1, which is legal.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs o_fetch_cnt[31:0] (pushed instructions) and o_wait_cnt[31:0] (RUN cycles with o_req=1 and no i_instr_valid, excluding the first cycle of each access).
  - Both reset to 0 and saturate at all-ones.
  - Dropped (redirected) responses count toward neither counter.
- When undefined: neither port nor logic exists, and behaviour is otherwise identical.

Decomposition:
- multicore_pkg gains:
  - fetch_entry_t packed struct {pc[ADDR_SIZE], instr[INST_SIZE]}.
  - fetch_state_t enum {RUN, STALL}.
  - Constant INST_BYTES = INST_SIZE/8, used as the PC increment.
- Sub-module fetch_fifo, parameterised by depth and entry type:
  - Ports: push, pop, flush, din, dout, count, empty, full.
  - Flush has priority over push/pop.

Test Plan:
- Reset, cache hits every request → o_addr 0,4,8,C at 2-cycle spacing. Decode sees PCs 0,4,8,C in order with matching instructions.
- Miss at 0x10: i_instr_valid withheld 20 cycles → o_addr held at 0x10 with o_req=1 for all 20 cycles; on the hit, FIFO gets {0x10, instr}, and the next o_addr is 0x14.
- i_ready=0, FIFO_DEPTH=2 → after 2 pushes, o_req=0 and o_addr frozen. Raising i_ready for 1 cycle → o_req=1 in that same cycle, and exactly one more fetch occurs.
- i_redirect to 0x200 at cycle 5 of a miss on 0x40 → FIFO flushed next cycle. The 0x40 response is dropped, o_addr becomes 0x200, and the first decoded PC is 0x200.
- i_redirect to 0x80 coincident with i_instr_valid → that instruction is not pushed, and the next o_addr is 0x80.
- Assert i_areset_n=0 mid-miss → next edge-independent: o_addr=RESET_PC, o_valid=0, o_req=1, FIFO empty. With IFETCH_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/multicore_pkg.sv
// Shared fetch types and constants: instruction width, fetch FIFO entry layout
// and the fetch FSM state encoding.
package multicore_pkg;

   localparam int INST_SIZE       = 32;
   localparam int INST_BYTES      = INST_SIZE / 8;
   localparam int FETCH_ADDR_SIZE = 32;

   typedef struct packed {
      logic [FETCH_ADDR_SIZE-1:0] pc;
      logic [INST_SIZE-1:0]       instr;
   } fetch_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO between fetch and decode. Flush wins over push/pop;
// the head entry is read straight out of the storage registers.
module fetch_fifo #(
   parameter int  DEPTH   = 2,
   parameter type entry_t = logic [63:0],
   localparam int CNT_W   = $clog2(DEPTH + 1),
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             i_clk,
   input  logic             i_areset_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  entry_t           din,
   output entry_t           dout,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // DEPTH is a power of two, so pointer wrap is the natural overflow
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, holds o_req/o_addr steady until the cache hits,
// and queues hits toward decode. Optional counters under IFETCH_PERF_CNT_EN.
module instr_fetch
   import multicore_pkg::*;
#(
   parameter int                    ADDR_SIZE  = 32,
   parameter logic [ADDR_SIZE-1:0]  RESET_PC   = ADDR_SIZE'(32'h0000_0000),
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                 i_clk,
   input  logic                 i_areset_n,
   output logic                 o_req,
   output logic [ADDR_SIZE-1:0] o_addr,
   input  logic                 i_instr_valid,
   input  logic [INST_SIZE-1:0] i_instruction,
   input  logic                 i_redirect,
   input  logic [ADDR_SIZE-1:0] i_redirect_pc,
   output logic                 o_valid,
   output logic [INST_SIZE-1:0] o_instr,
   output logic [ADDR_SIZE-1:0] o_pc,
   input  logic                 i_ready,
`ifdef IFETCH_PERF_CNT_EN
   output logic [31:0]          o_fetch_cnt,
   output logic [31:0]          o_wait_cnt,
`endif
   output fetch_state_t         o_dbg_state
);

   // Handshakes: o_req/o_addr are held constant until i_instr_valid is seen;
   // decode takes the head on a cycle where o_valid && i_ready.
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = {{(ADDR_SIZE-2){1'b1}}, 2'b00};

   typedef struct packed {
      logic [ADDR_SIZE-1:0] pc;
      logic [INST_SIZE-1:0] instr;
   } entry_t;

   fetch_state_t         state_q, state_d;
   logic [ADDR_SIZE-1:0] pc_q, pc_d;
   logic                 pend_q, pend_d;
   logic [ADDR_SIZE-1:0] pend_pc_q, pend_pc_d;
   logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [CNT_W-1:0]     fifo_count, count_after;
   entry_t               fifo_din, fifo_dout;
   logic [ADDR_SIZE-1:0] redirect_tgt;

   assign redirect_tgt = i_redirect_pc & ALIGN_MASK;
   assign fifo_push    = (state_q == RUN) && i_instr_valid && !i_redirect && !pend_q;
   assign fifo_pop     = !fifo_empty && i_ready && !i_redirect;
   assign count_after  = i_redirect ? '0
                       : fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
   assign fifo_din     = '{pc: pc_q, instr: i_instruction};

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;
      unique case (state_q)
         RUN: begin
            if (i_instr_valid) begin
               pend_d = 1'b0;
               if (i_redirect)  pc_d = redirect_tgt;
               else if (pend_q) pc_d = pend_pc_q;
               else             pc_d = pc_q + ADDR_SIZE'(INST_BYTES);
            end else if (i_redirect) begin
               // Access in flight: defer the jump until the cache answers
               pend_d    = 1'b1;
               pend_pc_d = redirect_tgt;
            end
            if (count_after == CNT_W'(FIFO_DEPTH)) state_d = STALL;
         end
         STALL: begin
            if (i_redirect) begin
               pc_d    = redirect_tgt;
               pend_d  = 1'b0;
               state_d = RUN;
            end else if (!fifo_full || fifo_pop) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC & ALIGN_MASK;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   // In STALL the request re-arms in the pop cycle, before the state flips
   assign o_req       = (state_q == RUN) || fifo_pop;
   assign o_addr      = pc_q;
   assign o_valid     = !fifo_empty;
   assign o_instr     = fifo_dout.instr;
   assign o_pc        = fifo_dout.pc;
   assign o_dbg_state = state_q;

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .i_clk      (i_clk),
      .i_areset_n (i_areset_n),
      .push       (fifo_push),
      .pop        (fifo_pop),
      .flush      (i_redirect),
      .din        (fifo_din),
      .dout       (fifo_dout),
      .count      (fifo_count),
      .empty      (fifo_empty),
      .full       (fifo_full)
   );

`ifdef IFETCH_PERF_CNT_EN
   logic first_q;

   // first_q marks the opening cycle of an access, which is not a wait cycle
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         first_q     <= 1'b1;
         o_fetch_cnt <= '0;
         o_wait_cnt  <= '0;
      end else begin
         first_q <= (state_q == STALL) || i_instr_valid;
         if (fifo_push && (o_fetch_cnt != '1))
            o_fetch_cnt <= o_fetch_cnt + 32'd1;
         if ((state_q == RUN) && !i_instr_valid && !first_q && (o_wait_cnt != '1))
            o_wait_cnt <= o_wait_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table, directed miss/redirect/reset sequences
// and random traffic checked against a queue-based fetch model.
module tb_instr_fetch;
   import multicore_pkg::*;

   localparam int DEPTH = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req;
   logic [31:0]  addr;
   logic         iv = 1'b0;
   logic [31:0]  ins = '0;
   logic         rdir = 1'b0;
   logic [31:0]  rpc = '0;
   logic         valid;
   logic [31:0]  o_ins;
   logic [31:0]  o_pc;
   logic         rdy = 1'b0;
   fetch_state_t dbg_state;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0]  fetch_cnt;
   logic [31:0]  wait_cnt;
`endif

   int checks = 0;
   int failures = 0;

   // model: expected PC, run/stall, pending redirect, and FIFO contents
   logic [31:0] m_pc;
   logic [31:0] m_pend_pc;
   bit          m_run;
   bit          m_pend;
   int          m_fetches;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   instr_fetch #(.ADDR_SIZE(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk         (clk),
      .i_areset_n    (rst_n),
      .o_req         (req),
      .o_addr        (addr),
      .i_instr_valid (iv),
      .i_instruction (ins),
      .i_redirect    (rdir),
      .i_redirect_pc (rpc),
      .o_valid       (valid),
      .o_instr       (o_ins),
      .o_pc          (o_pc),
      .i_ready       (rdy),
`ifdef IFETCH_PERF_CNT_EN
      .o_fetch_cnt   (fetch_cnt),
      .o_wait_cnt    (wait_cnt),
`endif
      .o_dbg_state   (dbg_state)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_pend_pc = '0; m_run = 1; m_pend = 0; m_fetches = 0;
      exp_q.delete();
   endtask

   // One clock: drive after the edge, compare at negedge, then advance model
   task automatic step(input bit s_iv, input logic [31:0] s_ins, input bit s_rd,
                       input logic [31:0] s_rpc, input bit s_rdy);
      bit pop;
      @(posedge clk); #1;
      iv = s_iv; ins = s_ins; rdir = s_rd; rpc = s_rpc; rdy = s_rdy;
      @(negedge clk);
      pop = (exp_q.size() > 0) && s_rdy && !s_rd;
      check("req", req, m_run || pop);
      check("addr", addr, m_pc);
      check("valid", valid, exp_q.size() > 0);
      check("state", dbg_state == STALL, !m_run);
      if (exp_q.size() > 0) begin
         check("head_pc", o_pc, exp_q[0][63:32]);
         check("head_instr", o_ins, exp_q[0][31:0]);
      end
`ifdef IFETCH_PERF_CNT_EN
      check("fetch_cnt", fetch_cnt, m_fetches);
`endif
      if (s_rd) exp_q.delete();
      else if (pop) void'(exp_q.pop_front());
      if (m_run) begin
         if (s_iv) begin
            if (s_rd) m_pc = s_rpc & ~32'h3;
            else if (m_pend) m_pc = m_pend_pc;
            else begin
               exp_q.push_back({m_pc, s_ins});
               m_fetches++;
               m_pc = m_pc + 32'd4;
            end
            m_pend = 0;
         end else if (s_rd) begin
            m_pend = 1;
            m_pend_pc = s_rpc & ~32'h3;
         end
         if (exp_q.size() == DEPTH) m_run = 0;
      end else if (s_rd) begin
         m_pc = s_rpc & ~32'h3;
         m_run = 1;
      end else if (exp_q.size() < DEPTH) begin
         m_run = 1;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"}, req, 1);
      check({tag, "_addr"}, addr, 32'h0);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_opc"}, o_pc, 32'h0);
      check({tag, "_oinstr"}, o_ins, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
      check({tag, "_fetch_cnt"}, fetch_cnt, 0);
      check({tag, "_wait_cnt"}, wait_cnt, 0);
`endif
   endtask

   task automatic do_reset();
      rst_n = 0; iv = 0; ins = '0; rdir = 0; rpc = '0; rdy = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      rst_n = 1;
   endtask

   typedef struct {
      bit          iv;
      logic [31:0] ins;
      bit          rd;
      logic [31:0] rpc;
      bit          rdy;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
   } vec_t;

   vec_t tbl[19];

   initial begin
      bit last_iv;
      tbl[0]  = '{0, 0, 0, 0, 0,                       1, 32'h0,   0, 0, 0};
      tbl[1]  = '{1, 32'hA000_0000, 0, 0, 0,           1, 32'h0,   0, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 0,                       1, 32'h4,   1, 32'h0, 32'hA000_0000};
      tbl[3]  = '{1, 32'hA000_0001, 0, 0, 0,           1, 32'h4,   1, 32'h0, 32'hA000_0000};
      tbl[4]  = '{0, 0, 0, 0, 0,                       0, 32'h8,   1, 32'h0, 32'hA000_0000};
      tbl[5]  = '{0, 0, 0, 0, 0,                       0, 32'h8,   1, 32'h0, 32'hA000_0000};
      tbl[6]  = '{0, 0, 0, 0, 1,                       1, 32'h8,   1, 32'h0, 32'hA000_0000};
      tbl[7]  = '{0, 0, 0, 0, 0,                       1, 32'h8,   1, 32'h4, 32'hA000_0001};
      tbl[8]  = '{1, 32'hA000_0002, 0, 0, 0,           1, 32'h8,   1, 32'h4, 32'hA000_0001};
      tbl[9]  = '{0, 0, 0, 0, 0,                       0, 32'hC,   1, 32'h4, 32'hA000_0001};
      tbl[10] = '{0, 0, 1, 32'h83, 1,                  0, 32'hC,   1, 32'h4, 32'hA000_0001};
      tbl[11] = '{0, 0, 1, 32'h100, 0,                 1, 32'h80,  0, 0, 0};
      tbl[12] = '{0, 0, 1, 32'h200, 0,                 1, 32'h80,  0, 0, 0};
      tbl[13] = '{1, 32'hDEAD_BEEF, 0, 0, 0,           1, 32'h80,  0, 0, 0};
      tbl[14] = '{0, 0, 0, 0, 0,                       1, 32'h200, 0, 0, 0};
      tbl[15] = '{1, 32'hB000_0000, 0, 0, 1,           1, 32'h200, 0, 0, 0};
      tbl[16] = '{0, 0, 0, 0, 1,                       1, 32'h204, 1, 32'h200, 32'hB000_0000};
      tbl[17] = '{1, 32'hB000_0001, 1, 32'h80, 1,      1, 32'h204, 0, 0, 0};
      tbl[18] = '{0, 0, 0, 0, 0,                       1, 32'h80,  0, 0, 0};

      do_reset();
      for (int i = 0; i < 19; i++) begin
         step(tbl[i].iv, tbl[i].ins, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
         check($sformatf("tbl%0d_req", i), req, tbl[i].e_req);
         check($sformatf("tbl%0d_addr", i), addr, tbl[i].e_addr);
         check($sformatf("tbl%0d_valid", i), valid, tbl[i].e_valid);
         if (tbl[i].e_valid) begin
            check($sformatf("tbl%0d_pc", i), o_pc, tbl[i].e_pc);
            check($sformatf("tbl%0d_ins", i), o_ins, tbl[i].e_ins);
         end
      end

      // Back-to-back hits: addresses 0,4,8,C and decode sees them in order
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 0, 1);
         check("seq_addr", addr, 32'(4 * k));
         if (k > 0) check("seq_dec_pc", o_pc, 32'(4 * (k - 1)));
         step(1, 32'h1000 + 32'(k), 0, 0, 1);
      end
      // 20-cycle miss at 0x10
      for (int c = 0; c < 20; c++) begin
         step(0, 0, 0, 0, 1);
         check("miss_addr", addr, 32'h10);
         check("miss_req", req, 1);
      end
      step(1, 32'h0000_1010, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("miss_next_addr", addr, 32'h14);
      check("miss_head_pc", o_pc, 32'h10);
      check("miss_head_ins", o_ins, 32'h0000_1010);

      // Redirect flushes a queued entry, then redirect mid-miss on 0x40
      step(1, 32'h0000_1014, 0, 0, 0);
      step(0, 0, 1, 32'h40, 0);
      check("flush_before", valid, 1);
      step(1, 32'hBAD0_0014, 0, 0, 0);
      check("flush_after", valid, 0);
      for (int c = 1; c <= 4; c++) step(0, 0, 0, 0, 1);
      check("rmiss_addr", addr, 32'h40);
      step(0, 0, 1, 32'h200, 1);
      step(1, 32'hBAD0_0040, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("rmiss_new_addr", addr, 32'h200);
      step(1, 32'h0000_2000, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("rmiss_first_pc", o_pc, 32'h200);
      check("rmiss_first_ins", o_ins, 32'h0000_2000);

      // Random traffic with a cache that answers at most every other cycle
      last_iv = 0;
      for (int n = 0; n < 400; n++) begin
         bit r_iv;
         r_iv = m_run && !last_iv && ($urandom_range(0, 2) == 0);
         step(r_iv, $urandom, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 1) == 1);
         last_iv = r_iv;
      end

      // PC wrap at the top of the address space
      do_reset();
      step(0, 0, 1, 32'hFFFF_FFFE, 1);
      step(1, 32'hBAD0_0000, 0, 0, 1);
      step(1, 32'hC0DE_0001, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      check("wrap_addr", addr, 32'h0);
      check("wrap_head_pc", o_pc, 32'hFFFF_FFFC);

      // Asynchronous reset in the middle of a miss with a queued entry
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("pre_rst_valid", valid, 1);
      @(posedge clk); #3;
      rst_n = 0;
      #1;
      check_reset_values("async_rst");
      do_reset();
      step(0, 0, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
